// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } f1_state_t;

  // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/f1_start_seq_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, reloads seed on reset.
module lfsr16
  import f1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: fill one light per tick, hold a pseudo-random time,
// then drop all lights with a one-cycle go pulse.
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int          N_LIGHTS = 8,
  parameter int          DLY_W    = 4,
  parameter int          MIN_HOLD = 2,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic                mode,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                go
);

  localparam int                  HW        = DLY_W + 1;
  localparam logic [N_LIGHTS-1:0] ALL_ON    = '1;
  localparam logic [N_LIGHTS-1:0] LAST_STEP = ALL_ON >> 1;

  f1_state_t           state, state_nx;
  logic [N_LIGHTS-1:0] data_nx;
  logic [HW-1:0]       hold_cnt, hold_nx, hold_load;
  logic                go_nx;
  logic [15:0]         lfsr_q;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Sampled from the current (pre-step) LFSR value on the filling edge.
  assign hold_load = HW'(lfsr_q[DLY_W-1:0]) + HW'(MIN_HOLD);

  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    data_nx  = data_out;
    hold_nx  = hold_cnt;
    go_nx    = 1'b0;
    case (state)
      IDLE: begin
        data_nx = '0;
        if (trigger) begin
          state_nx = FILL;
        end
      end
      FILL: begin
        if (en) begin
          if (data_out == LAST_STEP) begin
            data_nx  = ALL_ON;
            hold_nx  = hold_load;
            state_nx = HOLD;
          end else begin
            data_nx = {data_out[N_LIGHTS-2:0], 1'b1};
          end
        end
      end
      HOLD: begin
        data_nx = ALL_ON;
        if (en) begin
          if (hold_cnt == HW'(1)) begin
            data_nx  = '0;
            go_nx    = 1'b1;
            state_nx = mode ? FILL : IDLE;
          end else begin
            hold_nx = hold_cnt - HW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        data_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= '0;
      hold_cnt <= '0;
      go       <= 1'b0;
    end else begin
      state    <= state_nx;
      data_out <= data_nx;
      hold_cnt <= hold_nx;
      go       <= go_nx;
    end
  end

endmodule
